// File: rtl/cond_pkg.sv
// cond_pkg
// Shared definitions for the ARM-style conditional execution unit.
//   cond_e       : 4-bit ARM condition field encodings (EQ..AL, NV = illegal)
//   FLAG_N..V    : bit positions of each flag inside the {N,Z,C,V} vector
//   SQUASH_CNT_W : width of the optional squashed-instruction counter
//                  (present only when COND_STATS_EN is defined)
package cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'h0,
      NE = 4'h1,
      CS = 4'h2,
      CC = 4'h3,
      MI = 4'h4,
      PL = 4'h5,
      VS = 4'h6,
      VC = 4'h7,
      HI = 4'h8,
      LS = 4'h9,
      GE = 4'hA,
      LT = 4'hB,
      GT = 4'hC,
      LE = 4'hD,
      AL = 4'hE,
      NV = 4'hF
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int SQUASH_CNT_W = 16;

endpackage

// File: rtl/cond_check.sv
// cond_check
// Pure combinational evaluator: decides whether an ARM condition field
// passes against a given {N,Z,C,V} flag vector.
// Ports:
//   Cond   in  [3:0] condition field (Instr[31:28])
//   Flags  in  [3:0] flag vector {N,Z,C,V}
//   CondEx out       1 when the condition passes; always 0 for NV (4'hF)
module cond_check
   import cond_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   cond_e condCode;
   logic  flagN;
   logic  flagZ;
   logic  flagC;
   logic  flagV;
   logic  signedGe;

   assign condCode = cond_e'(Cond);
   assign flagN    = Flags[FLAG_N];
   assign flagZ    = Flags[FLAG_Z];
   assign flagC    = Flags[FLAG_C];
   assign flagV    = Flags[FLAG_V];
   assign signedGe = (flagN == flagV);

   // Standard ARM condition table. NV is the reserved encoding and never
   // passes, so it falls through to the default of 0.
   always_comb begin
      CondEx = 1'b0;
      case (condCode)
         EQ:      CondEx = flagZ;
         NE:      CondEx = ~flagZ;
         CS:      CondEx = flagC;
         CC:      CondEx = ~flagC;
         MI:      CondEx = flagN;
         PL:      CondEx = ~flagN;
         VS:      CondEx = flagV;
         VC:      CondEx = ~flagV;
         HI:      CondEx = flagC & ~flagZ;
         LS:      CondEx = ~flagC | flagZ;
         GE:      CondEx = signedGe;
         LT:      CondEx = ~signedGe;
         GT:      CondEx = ~flagZ & signedGe;
         LE:      CondEx = flagZ | ~signedGe;
         AL:      CondEx = 1'b1;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// cond_unit
// Conditional execution unit: holds the architectural {N,Z,C,V} flags,
// evaluates the instruction condition against them and gates the decoder's
// write requests.
// Optional feature macro: COND_STATS_EN adds a saturating SquashCount of
// instructions that were presented (en = 1) but failed their condition.
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   en                    instruction valid / advance (0 = stall)
//   Cond[3:0]             condition field
//   ALUFlags[3:0]         ALU result flags {N,Z,C,V}
//   FlagW[1:0]            bit1 writes N,Z ; bit0 writes C,V
//   PCS, RegW, MemW       decoder write requests
//   NoWrite               suppresses the register write (compare ops)
//   PCSrc, RegWrite,
//   MemWrite              gated write enables
//   CondEx                condition passed against the registered flags
//   CondIllegal           NV condition seen while en = 1
//   Flags[3:0]            architectural flag register
//   SquashCount[15:0]     squashed-instruction count (COND_STATS_EN only)
module cond_unit
   import cond_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    en,
   input  logic [3:0]              Cond,
   input  logic [3:0]              ALUFlags,
   input  logic [1:0]              FlagW,
   input  logic                    PCS,
   input  logic                    RegW,
   input  logic                    MemW,
   input  logic                    NoWrite,
   output logic                    PCSrc,
   output logic                    RegWrite,
   output logic                    MemWrite,
   output logic                    CondEx,
   output logic                    CondIllegal,
   output logic [3:0]              Flags
`ifdef COND_STATS_EN
   ,
   output logic [SQUASH_CNT_W-1:0] SquashCount
`endif
);

   logic [3:0] flagsQ;
   logic       condPass;
   logic       advance;

   // The condition is always judged against the registered flags, so an
   // instruction's own ALU result can only affect the next instruction.
   cond_check u_check (
      .Cond   (Cond),
      .Flags  (flagsQ),
      .CondEx (condPass)
   );

   assign advance     = en & condPass;
   assign CondEx      = condPass;
   assign CondIllegal = en & (Cond == NV);
   assign PCSrc       = advance & PCS;
   assign RegWrite    = advance & RegW & ~NoWrite;
   assign MemWrite    = advance & MemW;
   assign Flags       = flagsQ;

   // Flag register: N,Z and C,V are separate write groups so an instruction
   // that only sets carry/overflow leaves N,Z intact. A failed or stalled
   // instruction never touches the flags. The asynchronous clear also drops
   // any load that was set up for the next edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flagsQ <= 4'b0000;
      end else begin
         if (advance & FlagW[1]) begin
            flagsQ[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
         end
         if (advance & FlagW[0]) begin
            flagsQ[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
         end
      end
   end

`ifdef COND_STATS_EN
   logic [SQUASH_CNT_W-1:0] squashCnt;

   // Counts every presented instruction whose condition failed, which
   // includes the illegal NV encoding. Sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         squashCnt <= '0;
      end else if (en & ~condPass & (squashCnt != {SQUASH_CNT_W{1'b1}})) begin
         squashCnt <= squashCnt + 1'b1;
      end
   end

   assign SquashCount = squashCnt;
`endif

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have clock and reset first: clk input 1 (rising-edge clock); reset_n input 1 (reset, asynchronous, active-low).
REQ-002 SHALL have en input 1: instruction valid/advance; 0 = stall.
REQ-003 SHALL have Cond input 4: ARM condition field, Instr[31:28].
REQ-004 SHALL have ALUFlags input 4: current ALU flags, ordered {N,Z,C,V}.
REQ-005 SHALL have FlagW input 2: bit1 = write N,Z; bit0 = write C,V.
REQ-006 SHALL have PCS, RegW, MemW, NoWrite inputs 1 each: decoder write requests.
REQ-007 SHALL have PCSrc, RegWrite, MemWrite outputs 1 each: gated write enables.
REQ-008 SHALL have CondEx output 1: condition passed for the current instruction.
REQ-009 SHALL have CondIllegal output 1: Cond == 4'b1111 while en = 1.
REQ-010 SHALL have Flags output 4: architectural flag register {N,Z,C,V}.
REQ-011 SHALL have SquashCount output 16, present only when COND_STATS_EN is defined.

Function
REQ-012 SHALL evaluate CondEx combinationally against the registered Flags, never against same-cycle ALUFlags.
REQ-013 SHALL decode Cond as: 0 EQ Z; 1 NE ~Z; 2 CS C; 3 CC ~C; 4 MI N; 5 PL ~N; 6 VS V; 7 VC ~V; 8 HI C&~Z; 9 LS ~C|Z; A GE N==V; B LT N!=V; C GT ~Z&(N==V); D LE Z|(N!=V); E AL 1.
REQ-014 SHALL drive CondEx = 0 and CondIllegal = en for Cond = 4'b1111.
REQ-015 SHALL drive PCSrc = en & CondEx & PCS.
REQ-016 SHALL drive RegWrite = en & CondEx & RegW & ~NoWrite.
REQ-017 SHALL drive MemWrite = en & CondEx & MemW.
REQ-018 SHALL, on a rising clk edge with en & CondEx & FlagW[1], load Flags[3:2] from ALUFlags[3:2].
REQ-019 SHALL, on a rising clk edge with en & CondEx & FlagW[0], load Flags[1:0] from ALUFlags[1:0].
REQ-020 SHALL update each flag group independently, so a partial FlagW leaves the other group unchanged.
REQ-021 SHALL make updated flags visible on CondEx exactly one cycle after the updating edge (latency 1).
REQ-022 SHALL hold Flags when en = 0, with all write-enable outputs at 0 regardless of other inputs.
REQ-023 SHALL NOT update flags from a failed-condition instruction, including one with FlagW = 2'b11.

Reset
REQ-024 SHALL asynchronously clear Flags to 4'b0000 when reset_n = 0, independent of clk.
REQ-025 SHALL, during reset, drive CondEx from the cleared flags, so EQ reads 0 and NE reads 1.
REQ-026 SHALL cancel any pending flag load when reset asserts mid-cycle, with no update on the following edge.
REQ-027 SHALL clear SquashCount to 0 on reset when COND_STATS_EN is defined.

Configuration
REQ-028 SHALL, with COND_STATS_EN defined, increment SquashCount on each rising edge where en & ~CondEx, saturating at 16'hFFFF.
REQ-029 SHALL count illegal-Cond instructions as squashed.
REQ-030 SHALL, without COND_STATS_EN, omit the SquashCount port and counter entirely, with all other behaviour unchanged.

Structure
REQ-031 SHALL take from a shared package cond_pkg: enum cond_e (EQ..AL, NV = 4'hF); flag index constants FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0; SQUASH_CNT_W = 16.
REQ-032 SHALL place the pure combinational Cond/Flags evaluator in one sub-module, cond_check, instantiated once.
REQ-033 SHALL keep the flag registers, output gating and counter in cond_unit.

Verification
REQ-034 SHALL cover: reset, then Cond = 0 (EQ), en = 1 -> CondEx = 0; Cond = 1 (NE) -> CondEx = 1; Flags = 0000.
REQ-035 SHALL cover: Cond = E, FlagW = 11, ALUFlags = 0100 at edge -> Flags = 0100 next cycle; Cond = 0 then gives CondEx = 1 and RegW = 1 gives RegWrite = 1.
REQ-036 SHALL cover: Flags = 0100, Cond = 1 (NE), FlagW = 11, ALUFlags = 1010, RegW = MemW = PCS = 1 -> all write enables 0; Flags stay 0100; SquashCount + 1.
REQ-037 SHALL cover: Flags = 0000, FlagW = 01, ALUFlags = 1111, Cond = E -> Flags = 0011; Cond = B (LT) then gives CondEx = 1.
REQ-038 SHALL cover: en = 0 with Cond = E, FlagW = 11, ALUFlags = 1111 for 3 cycles -> Flags unchanged, outputs 0, SquashCount unchanged.
REQ-039 SHALL cover: Cond = F, en = 1 -> CondIllegal = 1, CondEx = 0; SquashCount forced to FFFF stays FFFF; reset_n pulsed low mid-cycle -> Flags = 0 immediately.
